// File: rtl/booth_iter_multiplier_pkg.sv
// Shared types and sizing helpers for the iterative radix-4 Booth multiplier.
package mul_pkg;

    localparam int MUL_WIDTH = 64;
    localparam int MUL_ROWS  = 4;

    function automatic int mul_len_f(input int width);
        return width + 1;
    endfunction

    function automatic int nrows_f(input int width);
        return (width + 2) / 2;
    endfunction

    function automatic int iter_f(input int width, input int rows);
        return (nrows_f(width) + rows - 1) / rows;
    endfunction

    // Wide enough that the exact per-iteration column total never wraps.
    function automatic int acc_w_f(input int width, input int rows);
        return mul_len_f(width) + 3 + 2 * rows;
    endfunction

    localparam int MUL_LEN   = mul_len_f(MUL_WIDTH);
    localparam int NROWS     = nrows_f(MUL_WIDTH);
    localparam int ITER      = iter_f(MUL_WIDTH, MUL_ROWS);
    localparam int MUL_ACC_W = acc_w_f(MUL_WIDTH, MUL_ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } MulState_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } BoothSel_t;

    function automatic BoothSel_t booth_sel_f(input logic [2:0] win);
        BoothSel_t sel;
        case (win)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_iter_multiplier_csa.sv
// Parameterised-width 3:2 carry-save adder used to build the row reduction tree.
module csa_3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);
    logic [W-1:0] maj_s;

    assign maj_s   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = maj_s << 1;

endmodule

// File: rtl/booth_iter_multiplier.sv
// Iterative radix-4 Booth multiplier, ROWS_PER_CYCLE rows per cycle into a carry-save accumulator.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips straight to DONE with a zero product.
module booth_iter_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH          = MUL_WIDTH,
    parameter int ROWS_PER_CYCLE = MUL_ROWS
) (
    input  logic                 iClock,
    input  logic                 iResetN,
    input  logic                 iInValid,
    output logic                 oInReady,
    input  logic [WIDTH-1:0]     iSrcA,
    input  logic [WIDTH-1:0]     iSrcB,
    input  logic                 iSignA,
    input  logic                 iSignB,
    input  logic                 iFlush,
    output logic                 oOutValid,
    input  logic                 iOutReady,
    output logic [2*WIDTH-1:0]   oProduct
);
    localparam int L_LEN   = mul_len_f(WIDTH);
    localparam int L_NROWS = nrows_f(WIDTH);
    localparam int L_ITER  = iter_f(WIDTH, ROWS_PER_CYCLE);
    localparam int L_ACC_W = acc_w_f(WIDTH, ROWS_PER_CYCLE);
    localparam int SH      = 2 * ROWS_PER_CYCLE;
    localparam int ROW_W   = L_LEN + 3;
    localparam int BW      = 2 * L_NROWS;
    localparam int LO_W    = SH * L_ITER;
    localparam int HI_W    = 2 * WIDTH - LO_W;
    localparam int CNT_W   = $clog2(L_ITER + 1);
    localparam int NOPS    = ROWS_PER_CYCLE + 3;

    MulState_t            state_q, state_d;
    logic [L_LEN-1:0]     a_q, a_d;
    logic [BW-1:0]        b_q, b_d;
    logic                 bm1_q, bm1_d;
    logic [L_ACC_W-1:0]   sum_q, sum_d, carry_q, carry_d;
    logic                 hc_q, hc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LO_W-1:0]      lo_q, lo_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 in_ready_q, out_valid_q;

    logic [L_LEN:0]       bx_s;
    logic [SH:0]          win_src_s;
    BoothSel_t            sel_s  [ROWS_PER_CYCLE];
    logic [L_LEN:0]       pp_s   [ROWS_PER_CYCLE];
    logic                 ng_s   [ROWS_PER_CYCLE];
    logic                 ok_s   [ROWS_PER_CYCLE];
    logic [ROW_W-1:0]     row_s  [ROWS_PER_CYCLE];
    logic [L_ACC_W-1:0]   neg_vec_s;
    logic [L_ACC_W-1:0]   op_s   [NOPS];
    logic [L_ACC_W-1:0]   ts_s   [ROWS_PER_CYCLE+1];
    logic [L_ACC_W-1:0]   tc_s   [ROWS_PER_CYCLE+1];
    logic [SH:0]          lo_sum_s;
    logic [HI_W-1:0]      hi_s;

    // Booth row generation; sign extension folded into the {~s,s,s} / {1,~s} prefixes.
    always_comb begin
        win_src_s = {b_q[SH-1:0], bm1_q};
        neg_vec_s = '0;
        for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
            sel_s[k] = booth_sel_f(win_src_s[2*k +: 3]);
            ok_s[k]  = ((int'(cnt_q) * ROWS_PER_CYCLE + k) < L_NROWS);
            case (sel_s[k])
                POS1: begin pp_s[k] = {a_q[L_LEN-1], a_q};    ng_s[k] = 1'b0; end
                POS2: begin pp_s[k] = {a_q, 1'b0};            ng_s[k] = 1'b0; end
                NEG1: begin pp_s[k] = ~{a_q[L_LEN-1], a_q};   ng_s[k] = 1'b1; end
                NEG2: begin pp_s[k] = ~{a_q, 1'b0};           ng_s[k] = 1'b1; end
                default: begin pp_s[k] = '0;                  ng_s[k] = 1'b0; end
            endcase
            if (!ok_s[k]) begin
                row_s[k] = '0;
            end else if ((cnt_q == '0) && (k == 0)) begin
                row_s[k] = {~pp_s[k][L_LEN], pp_s[k][L_LEN], pp_s[k][L_LEN], pp_s[k][L_LEN-1:0]};
            end else begin
                row_s[k] = {1'b0, 1'b1, ~pp_s[k][L_LEN], pp_s[k][L_LEN-1:0]};
            end
            neg_vec_s[2*k] = ng_s[k] & ok_s[k];
            op_s[3+k] = {{(L_ACC_W-ROW_W){1'b0}}, row_s[k]} << (2 * k);
        end
        op_s[0] = sum_q;
        op_s[1] = carry_q;
        op_s[2] = neg_vec_s;
    end

    genvar g;
    generate
        for (g = 0; g <= ROWS_PER_CYCLE; g++) begin : g_csa
            if (g == 0) begin : g_first
                csa_3to2 #(.W(L_ACC_W)) u_csa (
                    .a_i(op_s[0]), .b_i(op_s[1]), .c_i(op_s[2]),
                    .sum_o(ts_s[0]), .carry_o(tc_s[0])
                );
            end else begin : g_next
                csa_3to2 #(.W(L_ACC_W)) u_csa (
                    .a_i(ts_s[g-1]), .b_i(tc_s[g-1]), .c_i(op_s[g+2]),
                    .sum_o(ts_s[g]), .carry_o(tc_s[g])
                );
            end
        end
    endgenerate

    assign lo_sum_s = {1'b0, ts_s[ROWS_PER_CYCLE][SH-1:0]} + {1'b0, tc_s[ROWS_PER_CYCLE][SH-1:0]}
                    + {{SH{1'b0}}, hc_q};
    assign hi_s     = sum_q[HI_W-1:0] + carry_q[HI_W-1:0] + {{(HI_W-1){1'b0}}, hc_q};
    assign bx_s     = {iSignB & iSrcB[WIDTH-1], iSrcB};

    // Next-state and datapath update; flush overrides every state.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        bm1_d   = bm1_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        hc_d    = hc_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        if (iFlush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iInValid) begin
                        a_d     = {iSignA & iSrcA[WIDTH-1], iSrcA};
                        b_d     = {{(BW-L_LEN){bx_s[L_LEN-1]}}, bx_s[L_LEN-1:0]};
                        bm1_d   = 1'b0;
                        sum_d   = '0;
                        carry_d = '0;
                        hc_d    = 1'b0;
                        cnt_d   = '0;
`ifdef MUL_ZERO_BYPASS_EN
                        if ((iSrcA == '0) || (iSrcB == '0)) begin
                            state_d = DONE;
                            prod_d  = '0;
                        end else begin
                            state_d = BUSY;
                        end
`else
                        state_d = BUSY;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                BUSY: begin
                    sum_d   = ts_s[ROWS_PER_CYCLE] >> SH;
                    carry_d = tc_s[ROWS_PER_CYCLE] >> SH;
                    hc_d    = lo_sum_s[SH];
                    lo_d    = {lo_sum_s[SH-1:0], lo_q[LO_W-1:SH]};
                    b_d     = b_q >> SH;
                    bm1_d   = b_q[SH-1];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(L_ITER - 1)) begin
                        state_d = FINAL;
                    end else begin
                        state_d = BUSY;
                    end
                end
                FINAL: begin
                    prod_d  = {hi_s, lo_q};
                    state_d = DONE;
                end
                DONE: begin
                    if (iOutReady) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge iClock) begin
        if (!iResetN) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            bm1_q       <= 1'b0;
            sum_q       <= '0;
            carry_q     <= '0;
            hc_q        <= 1'b0;
            cnt_q       <= '0;
            lo_q        <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            bm1_q       <= bm1_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            hc_q        <= hc_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            prod_q      <= prod_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign oInReady  = in_ready_q;
    assign oOutValid = out_valid_q;
    assign oProduct  = prod_q;

endmodule
